conv2d_window_gen: RTL and testbench
====================================

# conv2d_window_gen

Streaming 3×3 sliding-window generator that feeds `conv2d_pe`. It accepts one multi-channel pixel per cycle in raster order and keeps two line buffers per channel. For each valid-padding output position it presents a stable `window_per_channel` bundle and pulses `start`. It then stalls its input until the PE reports completion through `pe_done`, which is wired to PE `out_valid`.

## Interface
Parameters:
- `IMG_W`, default 8: frame width in pixels (≥3)
- `IMG_H`, default 8: frame height in pixels (≥3)
- `CHANNELS`, default 3: input channels, shared from `conv2d_params.svh`
- `PIXEL_WIDTH`, default 8: bits per channel sample
- `WINDOW_ELEMS`, default 9: fixed 3×3 window; no other value is supported

Ports:
- `clk`  in  1: single clock, rising edge
- `rst`  in  1: reset, synchronous and active-high
- `in_px`  in  CHANNELS×PIXEL_WIDTH: one pixel, all channels; `[ch]` slice is channel ch
- `in_valid`  in  1: `in_px` valid
- `in_ready`  out  1: block accepts `in_px` this cycle
- `window_per_channel`  out  CHANNELS×WINDOW_ELEMS×PIXEL_WIDTH: current window, same packing as the PE input
- `start`  out  1: one-cycle pulse; window is valid for the PE
- `pe_done`  in  1: PE result produced; connect to PE `out_valid`
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept: a pixel is accepted on a cycle with `in_valid && in_ready`. Only accepted pixels advance the counters.
- Counters:
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no gap.
- Line buffers:
  - `lb1[c]` holds row r-2 and `lb0[c]` holds row r-1, per channel.
  - On accept at column c: `lb1[c] <= lb0[c]` and `lb0[c] <= in_px`, read before write.
- Window shift register: 3×3 per channel. On accept, columns shift left and the new right column becomes {`lb1[c]`, `lb0[c]`, `in_px`}, top to bottom.
- Element order: e = 3·wr + wc.
  - wr=0 is the top row (r-2); wc=0 is the left column (c-2).
  - e=0 is the oldest sample and e=8 is the just-accepted pixel.
- Window emit: if the accepted pixel has row≥2 and col≥2, the window is complete.
  - The block registers `start`=1 for the next cycle and sets `busy`.
  - Windows at col<2 hold stale columns from the previous row and are never emitted.
- Output count: (IMG_W-2)·(IMG_H-2) `start` pulses per frame.
- States:
  - IDLE/STREAM (`busy`=0): `in_ready`=1.
  - WAIT_PE (`busy`=1): `in_ready`=0. The shift register and line buffers are frozen, so `window_per_channel` stays stable for the whole PE computation.
  - WAIT_PE → STREAM on `pe_done`=1.
- `window_per_channel` is driven directly from the shift register, with no extra copy.
- Samples are passed through unmodified; the PE interprets them as signed.

## Timing
- Reset values: `in_ready`=1 on the first cycle after `rst` deasserts. `start`=0, `frame_done`=0, `busy`=0, `row`=`col`=0, window registers all 0.
  - Line buffers need not be reset; they are not observable before row 2.
- Accept at cycle N with a complete window:
  - `start`=1 at N+1 only; `in_ready`=0 from N+1.
  - `window_per_channel` holds the new value from N+1 until the next accept.
- `pe_done`=1 at cycle M while busy: `busy` clears, so `in_ready`=1 at M+1. With the 27-cycle PE, the minimum accept-to-accept spacing on emitting pixels is about 29 cycles.
- Ignored `pe_done`: when not busy, and at the same cycle as `start`.
- Non-emitting pixels (row<2 or col<2) are accepted back-to-back at one per cycle.
- `frame_done`: pulses at N+1 for the accept of pixel (IMG_H-1, IMG_W-1). It coincides with that pixel's `start`.
- Reset mid-frame or mid-WAIT_PE discards all state. After reset the block behaves as at power-up, and any in-flight PE result is the integrator's concern.
- Gaps in `in_valid` never change state.

## Test plan
- Reset: hold `rst` 2 cycles, then check `in_ready`=1, `start`=0, `frame_done`=0, window all 0.
- Single frame, IMG_W=IMG_H=4: feed ch0=r·4+c, ch1=ch0+64, ch2=ch0+128. Model `pe_done` 27 cycles after each `start`. Expect:
  - exactly 4 `start` pulses;
  - first window ch0 = {0,1,2,4,5,6,8,9,10}, ch2 e=8 = 138;
  - last window ch0 e=0 = 5, e=8 = 15.
- Stall: hold `pe_done` low for 100 cycles after a `start` with `in_valid` high. Expect `in_ready`=0 and the window unchanged throughout; one cycle after `pe_done`, `in_ready`=1.
- Row wrap: at IMG_W=4, check no `start` for the accepts at (3,0) and (3,1) despite row≥2.
- Back-to-back frames: stream 2 frames with no gap. Expect `frame_done` exactly twice, 8 starts total, and the second frame's first window equal to the first frame's.
- Mid-frame reset: assert `rst` during WAIT_PE at pixel (2,3). Expect `in_ready`=1, counters 0, and the next full frame producing the correct 4 windows.

Source files
------------

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen
//   Streaming 3x3 sliding-window generator feeding conv2d_pe. It takes one multi-channel pixel
//   per cycle in raster order and keeps two line buffers per channel. Each valid-padding window
//   is presented on window_per_channel with a one-cycle start pulse. Input then stalls until
//   pe_done is seen.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_px               one pixel, channel ch in [ch*PIXEL_WIDTH +: PIXEL_WIDTH]
//   in_valid            in_px valid
//   in_ready            pixel accepted this cycle when in_valid is also high
//   window_per_channel  element e of channel ch at [(ch*WINDOW_ELEMS+e)*PIXEL_WIDTH +: PIXEL_WIDTH]
//                       e = 3*wr + wc; e=0 is the oldest sample, e=8 the newest
//   start               one-cycle pulse, window valid for the PE
//   pe_done             PE result produced (PE out_valid)
//   frame_done          one-cycle pulse after the last pixel of a frame is accepted
//
// WINDOW_ELEMS is fixed at 9; the shift-register layout assumes a 3x3 window.
module conv2d_window_gen #(
   parameter int unsigned IMG_W        = 8,
   parameter int unsigned IMG_H        = 8,
   parameter int unsigned CHANNELS     = 3,
   parameter int unsigned PIXEL_WIDTH  = 8,
   parameter int unsigned WINDOW_ELEMS = 9
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [CHANNELS*PIXEL_WIDTH-1:0]            in_px,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   output logic [CHANNELS*WINDOW_ELEMS*PIXEL_WIDTH-1:0] window_per_channel,
   output logic                                       start,
   input  logic                                       pe_done,
   output logic                                       frame_done
);

   localparam int unsigned PxW  = CHANNELS * PIXEL_WIDTH;
   localparam int unsigned WinW = CHANNELS * WINDOW_ELEMS * PIXEL_WIDTH;
   localparam int unsigned ColW = $clog2(IMG_W);
   localparam int unsigned RowW = $clog2(IMG_H);
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   typedef enum logic [0:0] {StStream, StWaitPe} state_e;

   state_e          state_q;
   logic [ColW-1:0] col_q;
   logic [RowW-1:0] row_q;
   logic            start_q;
   logic            frame_done_q;
   logic [WinW-1:0] win_q, win_d;
   logic [PxW-1:0]  lb0_q [IMG_W];  // row r-1
   logic [PxW-1:0]  lb1_q [IMG_W];  // row r-2

   logic accept;
   logic emit;
   logic last_px;

   assign in_ready           = (state_q == StStream);
   assign accept             = in_valid && in_ready;
   assign emit               = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
   assign last_px            = (row_q == RowLast) && (col_q == ColLast);
   assign start              = start_q;
   assign frame_done         = frame_done_q;
   assign window_per_channel = win_q;

   // Shift each window row left by one column; the new right column is the current column of
   // both line buffers (read before they are overwritten) plus the incoming pixel.
   always_comb begin
      win_d = win_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 2; wc++) begin
               win_d[(ch*WINDOW_ELEMS + 3*wr + wc)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                  win_q[(ch*WINDOW_ELEMS + 3*wr + wc + 1)*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
         end
         win_d[(ch*WINDOW_ELEMS + 2)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            lb1_q[col_q][ch*PIXEL_WIDTH +: PIXEL_WIDTH];
         win_d[(ch*WINDOW_ELEMS + 5)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            lb0_q[col_q][ch*PIXEL_WIDTH +: PIXEL_WIDTH];
         win_d[(ch*WINDOW_ELEMS + 8)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            in_px[ch*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   // Line buffers are not reset: rows 0 and 1 of every frame overwrite them before any
   // emitted window can read them.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= in_px;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StStream;
         col_q        <= '0;
         row_q        <= '0;
         start_q      <= 1'b0;
         frame_done_q <= 1'b0;
         win_q        <= '0;
      end else begin
         start_q      <= 1'b0;
         frame_done_q <= 1'b0;
         if (accept) begin
            win_q        <= win_d;
            frame_done_q <= last_px;
            if (col_q == ColLast) begin
               col_q <= '0;
               row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
            if (emit) begin
               start_q <= 1'b1;
               state_q <= StWaitPe;
            end
         end else if (state_q == StWaitPe && pe_done && !start_q) begin
            // pe_done coinciding with start belongs to an older request and is ignored
            state_q <= StStream;
         end
      end
   end

endmodule

// File: tb/tb_conv2d_window_gen.sv
module tb_conv2d_window_gen;

   localparam int unsigned W    = 4;
   localparam int unsigned H    = 4;
   localparam int unsigned CH   = 3;
   localparam int unsigned PW   = 8;
   localparam int unsigned WE   = 9;
   localparam int unsigned PxW  = CH * PW;
   localparam int unsigned WinW = CH * WE * PW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            pe_done = 1'b0;
   logic [PxW-1:0]  in_px = '0;
   logic            in_ready;
   logic            start;
   logic            frame_done;
   logic [WinW-1:0] window;

   conv2d_window_gen #(
      .IMG_W        (W),
      .IMG_H        (H),
      .CHANNELS     (CH),
      .PIXEL_WIDTH  (PW),
      .WINDOW_ELEMS (WE)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .in_px              (in_px),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .window_per_channel (window),
      .start              (start),
      .pe_done            (pe_done),
      .frame_done         (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [WinW-1:0] act,
                        input logic [WinW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [PxW-1:0]  img [H][W];
   logic [WinW-1:0] exp_q [$];
   int m_row = 0;
   int m_col = 0;
   bit m_busy = 0, e_start = 0, e_fd = 0, prev_rst = 1;

   function automatic logic [WinW-1:0] ref_window(int r, int c);
      logic [WinW-1:0] w = '0;
      for (int ch = 0; ch < CH; ch++)
         for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++)
               w[(ch*WE + 3*wr + wc)*PW +: PW] = img[r-2+wr][c-2+wc][ch*PW +: PW];
      return w;
   endfunction

   initial forever begin
      bit acc, nb, ns, nf;
      @(negedge clk);
      if (rst) begin
         m_row = 0; m_col = 0; m_busy = 0; e_start = 0; e_fd = 0; prev_rst = 1;
         exp_q.delete();
      end else begin
         if (prev_rst) check("reset_window", window, '0);
         prev_rst = 0;
         check("in_ready", in_ready, !m_busy);
         check("start", start, e_start);
         check("frame_done", frame_done, e_fd);
         acc = in_valid && !m_busy;
         nb  = m_busy;
         ns  = 0;
         nf  = 0;
         if (m_busy && pe_done && !e_start) nb = 0;
         if (acc) begin
            img[m_row][m_col] = in_px;
            if (m_row >= 2 && m_col >= 2) begin
               exp_q.push_back(ref_window(m_row, m_col));
               ns = 1;
               nb = 1;
            end
            if (m_row == H-1 && m_col == W-1) nf = 1;
            if (m_col == W-1) begin
               m_col = 0;
               m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
         m_busy = nb; e_start = ns; e_fd = nf;
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [WinW-1:0] held;
   logic [WinW-1:0] seen [$];
   bit have_held = 0;
   int start_cnt = 0;
   int fd_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         have_held = 0;
      end else begin
         if (frame_done) fd_cnt++;
         if (start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL window_unexpected: got start=1 expected no window pending at %0t",
                        $time);
            end else begin
               check("window", window, exp_q.pop_front());
            end
            held = window;
            have_held = 1;
            seen.push_back(window);
         end else if (!in_ready && have_held) begin
            check("window_stable", window, held);
         end
      end
   end

   // ---------------- PE model ----------------
   int pe_lat = 27;
   int pe_cnt = 0;
   bit pe_noise = 0;
   bit rand_lat = 0;

   initial forever begin
      @(posedge clk);
      #1;
      pe_done = 1'b0;
      if (rst) begin
         pe_cnt = 0;
      end else if (start) begin
         pe_cnt = rand_lat ? int'($urandom_range(40, 1)) : pe_lat;
         if (pe_noise) pe_done = ($urandom % 2) == 1;  // must be ignored
      end else if (pe_cnt > 0) begin
         pe_cnt--;
         if (pe_cnt == 0) pe_done = 1'b1;
      end else if (pe_noise) begin
         pe_done = ($urandom % 3) == 0;  // not busy: must be ignored
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_px(input logic [PxW-1:0] px, input int gap);
      bit done = 0;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_px    = px;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      if (!done) begin
         n_checks++;
         n_fails++;
         $display("FAIL accept_timeout: got in_ready=0 for 2000 cycles expected accept");
      end
   endtask

   task automatic wait_idle();
      bit done = 0;
      in_valid = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1;
      end
      if (!done) begin
         n_checks++;
         n_fails++;
         $display("FAIL idle_timeout: got in_ready=0 for 1000 cycles expected 1");
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [PxW-1:0] pat_px(int r, int c);
      logic [PxW-1:0] p;
      for (int ch = 0; ch < CH; ch++) p[ch*PW +: PW] = PW'(r*4 + c + 64*ch);
      return p;
   endfunction

   function automatic logic [WinW-1:0] first_win();
      int base [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      logic [WinW-1:0] w;
      for (int ch = 0; ch < CH; ch++)
         for (int e = 0; e < 9; e++) w[(ch*WE + e)*PW +: PW] = PW'(base[e] + 64*ch);
      return w;
   endfunction

   task automatic pattern_frame();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) send_px(pat_px(r, c), 0);
   endtask

   initial begin
      logic [WinW-1:0] w;

      // reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // two back-to-back pattern frames
      start_cnt = 0; fd_cnt = 0; seen.delete();
      pattern_frame();
      pattern_frame();
      wait_idle();
      check("starts_2frames", start_cnt, 8);
      check("frame_done_2frames", fd_cnt, 2);
      if (seen.size() >= 5) begin
         w = seen[0];
         check("first_window", w, first_win());
         check("first_ch2_e8", w[(2*WE + 8)*PW +: PW], 138);
         w = seen[3];
         check("last_ch0_e0", w[0 +: PW], 5);
         check("last_ch0_e8", w[8*PW +: PW], 15);
         w = seen[4];
         check("frame2_first_window", w, first_win());
      end else begin
         check("seen_windows", seen.size(), 8);
      end

      // long PE stall with in_valid held high
      pe_lat = 100;
      start_cnt = 0;
      pattern_frame();
      wait_idle();
      check("starts_stall", start_cnt, 4);
      pe_lat = 27;

      // reset while waiting on the PE after pixel (2,3)
      for (int i = 0; i < 12; i++) send_px(pat_px(i / 4, i % 4), 0);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      start_cnt = 0; fd_cnt = 0; seen.delete();
      pattern_frame();
      wait_idle();
      check("starts_after_reset", start_cnt, 4);
      check("frame_done_after_reset", fd_cnt, 1);
      if (seen.size() > 0) begin
         w = seen[0];
         check("first_window_after_reset", w, first_win());
      end

      // random pixels, gaps, PE latencies and stray pe_done
      pe_noise = 1; rand_lat = 1;
      start_cnt = 0; fd_cnt = 0;
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < W*H; i++)
            send_px(PxW'($urandom), ($urandom % 3 == 0) ? int'($urandom_range(3, 1)) : 0);
      wait_idle();
      check("starts_random", start_cnt, 12);
      check("frame_done_random", fd_cnt, 3);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
